// File: rtl/pc_fetch_ctrl.sv
// Fetch-side PC controller: sequences instruction memory requests,
// applies execute-stage redirects and registers the fetched word.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redir_valid,
  input  logic [2:0]  redir_op,
  input  logic [31:0] redir_pc,
  input  logic [31:0] redir_imm,
  input  logic [31:0] redir_rs1,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    BOOT,
    REQ,
    HOLD,
    HALT
  } state_t;

  state_t      state;
  state_t      state_d;
  logic [31:0] pc;
  logic [31:0] pc_d;
  logic [31:0] pend_pc;
  logic [31:0] pend_pc_d;
  logic        pend;
  logic        pend_d;
  logic        vld_d;
  logic [31:0] inst_d;
  logic [31:0] ipc_d;
  logic        err_d;

  logic        redir_ok;
  logic [31:0] tgt;
  logic        tmis;

  always_comb begin
    redir_ok = 1'b0;
    tgt      = redir_pc + redir_imm;
    if (redir_valid) begin
      case (redir_op)
        3'b001, 3'b010: redir_ok = 1'b1;
        3'b100: begin
          redir_ok = 1'b1;
          tgt      = (redir_rs1 + redir_imm) & ~32'h1;
        end
        default: redir_ok = 1'b0;
      endcase
    end
    tmis = |tgt[1:0];
  end

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;

  always_comb begin
    state_d   = state;
    pc_d      = pc;
    pend_d    = pend;
    pend_pc_d = pend_pc;
    vld_d     = inst_valid;
    inst_d    = inst;
    ipc_d     = inst_pc;
    err_d     = misalign_err;
    unique case (state)
      BOOT: begin
        vld_d   = 1'b0;
        state_d = REQ;
        if (redir_ok && tmis) begin
          err_d   = 1'b1;
          state_d = HALT;
        end else if (redir_ok) begin
          pc_d = tgt;
        end
      end
      REQ: begin
        vld_d = 1'b0;
        if (redir_ok && tmis) begin
          err_d   = 1'b1;
          pend_d  = 1'b0;
          state_d = HALT;
        end else if (redir_ok && imem_ack) begin
          pc_d   = tgt;
          pend_d = 1'b0;
        end else if (redir_ok) begin
          // address must stay put until the ack, so park the target
          pend_d    = 1'b1;
          pend_pc_d = tgt;
        end else if (imem_ack && pend) begin
          pc_d   = pend_pc;
          pend_d = 1'b0;
        end else if (imem_ack) begin
          vld_d   = 1'b1;
          inst_d  = imem_rdata;
          ipc_d   = pc;
          pc_d    = pc + 32'd4;
          state_d = stall ? HOLD : REQ;
        end
      end
      HOLD: begin
        if (redir_ok && tmis) begin
          vld_d   = 1'b0;
          err_d   = 1'b1;
          state_d = HALT;
        end else if (redir_ok) begin
          vld_d   = 1'b0;
          pc_d    = tgt;
          state_d = REQ;
        end else if (!stall) begin
          vld_d   = 1'b0;
          state_d = REQ;
        end
      end
      HALT: begin
        vld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      pend         <= 1'b0;
      pend_pc      <= 32'h0;
      inst_valid   <= 1'b0;
      inst         <= 32'h0;
      inst_pc      <= 32'h0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_d;
      pc           <= pc_d;
      pend         <= pend_d;
      pend_pc      <= pend_pc_d;
      inst_valid   <= vld_d;
      inst         <= inst_d;
      inst_pc      <= ipc_d;
      misalign_err <= err_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed fetch/redirect/stall sequences
// with a scoreboard of accepted fetches.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rstn;
  logic        redir_valid;
  logic [2:0]  redir_op;
  logic [31:0] redir_pc;
  logic [31:0] redir_imm;
  logic [31:0] redir_rs1;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        misalign_err;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t sbq[$];
  int   checks;
  int   errors;

  localparam logic [2:0] BR   = 3'b001;
  localparam logic [2:0] JMP  = 3'b010;
  localparam logic [2:0] JALR = 3'b100;

  pc_fetch_ctrl #(.RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .redir_valid  (redir_valid),
    .redir_op     (redir_op),
    .redir_pc     (redir_pc),
    .redir_imm    (redir_imm),
    .redir_rs1    (redir_rs1),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic redir(input logic [2:0] op, input logic [31:0] p,
                       input logic [31:0] imm, input logic [31:0] rs1);
    redir_valid = 1'b1;
    redir_op    = op;
    redir_pc    = p;
    redir_imm   = imm;
    redir_rs1   = rs1;
  endtask

  task automatic clr();
    redir_valid = 1'b0;
    redir_op    = 3'b000;
    imem_ack    = 1'b0;
  endtask

  // One REQ cycle at expected address ea; keep marks an accepted fetch.
  task automatic fetch(input logic [31:0] ea, input logic ack,
                       input logic st, input logic keep);
    exp_t e;
    chk("req", 32'(imem_req), 32'd1);
    chk("addr", imem_addr, ea);
    imem_ack   = ack;
    stall      = st;
    imem_rdata = memf(ea);
    if (keep) sbq.push_back('{pc: ea, ins: memf(ea)});
    @(posedge clk);
    @(negedge clk);
    clr();
    if (keep) begin
      chk("vld", 32'(inst_valid), 32'd1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("inst", inst, e.ins);
        chk("ipc", inst_pc, e.pc);
      end
    end else begin
      chk("novld", 32'(inst_valid), 32'd0);
    end
  endtask

  // A cycle with no expected request; ack is raised to prove it is ignored.
  task automatic idle(input logic st, input logic evld);
    chk("noreq", 32'(imem_req), 32'd0);
    stall      = st;
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    @(posedge clk);
    @(negedge clk);
    clr();
    chk("ivld", 32'(inst_valid), 32'(evld));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clr();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_vld", 32'(inst_valid), 32'd0);
    chk("rst_err", 32'(misalign_err), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_ipc", inst_pc, 32'h0);
    sbq.delete();
    rstn = 1'b1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rstn        = 1'b0;
    stall       = 1'b0;
    redir_pc    = 32'h0;
    redir_imm   = 32'h0;
    redir_rs1   = 32'h0;
    imem_rdata  = 32'h0;
    clr();
    @(negedge clk);
    do_reset();

    // sequential fetch
    idle(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) fetch(32'(i * 4), 1'b1, 1'b0, 1'b1);

    // branch while waiting for ack
    redir(BR, 32'h100, 32'h20, 32'h0);
    fetch(32'h10, 1'b0, 1'b0, 1'b0);
    fetch(32'h10, 1'b0, 1'b0, 1'b0);
    fetch(32'h10, 1'b0, 1'b0, 1'b0);
    fetch(32'h10, 1'b1, 1'b0, 1'b0);
    fetch(32'h120, 1'b1, 1'b0, 1'b1);

    // redirect with same-cycle ack, ignored ops
    redir(JMP, 32'h200, 32'h40, 32'h0);
    fetch(32'h124, 1'b1, 1'b0, 1'b0);
    redir(3'b000, 32'h500, 32'h0, 32'h0);
    fetch(32'h240, 1'b1, 1'b0, 1'b1);
    redir(3'b011, 32'h500, 32'h0, 32'h0);
    fetch(32'h244, 1'b1, 1'b0, 1'b1);

    // latest pending redirect wins
    redir(JMP, 32'h600, 32'h0, 32'h0);
    fetch(32'h248, 1'b0, 1'b0, 1'b0);
    redir(JMP, 32'h700, 32'h0, 32'h0);
    fetch(32'h248, 1'b0, 1'b0, 1'b0);
    fetch(32'h248, 1'b1, 1'b0, 1'b0);
    redir(JMP, 32'h800, 32'h0, 32'h0);
    fetch(32'h700, 1'b0, 1'b0, 1'b0);
    redir(JMP, 32'h900, 32'h0, 32'h0);
    fetch(32'h700, 1'b1, 1'b0, 1'b0);
    fetch(32'h900, 1'b1, 1'b0, 1'b1);
    fetch(32'h904, 1'b1, 1'b0, 1'b1);

    // jalr, including bit0 clear
    redir(JALR, 32'h0, 32'h3, 32'h201);
    fetch(32'h908, 1'b1, 1'b0, 1'b0);
    fetch(32'h204, 1'b1, 1'b0, 1'b1);
    chk("jalr_err", 32'(misalign_err), 32'd0);
    redir(JALR, 32'h0, 32'h0, 32'h301);
    fetch(32'h208, 1'b1, 1'b0, 1'b0);
    fetch(32'h300, 1'b1, 1'b0, 1'b1);

    // stall hold, redirect out of hold, plain hold release
    redir(JMP, 32'h0, 32'h40, 32'h0);
    fetch(32'h304, 1'b1, 1'b0, 1'b0);
    fetch(32'h40, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1, 1'b1);
      chk("hinst", inst, 32'hDEADBEEF);
      chk("hipc", inst_pc, 32'h40);
    end
    redir(JMP, 32'h80, 32'h0, 32'h0);
    idle(1'b1, 1'b0);
    fetch(32'h80, 1'b1, 1'b1, 1'b1);
    idle(1'b0, 1'b0);
    fetch(32'h84, 1'b1, 1'b0, 1'b1);

    // pc wrap, then reset mid-wait
    redir(JMP, 32'hFFFF_FFF0, 32'hC, 32'h0);
    fetch(32'h88, 1'b1, 1'b0, 1'b0);
    fetch(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1);
    chk("wrap_err", 32'(misalign_err), 32'd0);
    fetch(32'h0, 1'b0, 1'b0, 1'b0);
    do_reset();

    // redirect during boot
    redir(JMP, 32'h300, 32'h0, 32'h0);
    idle(1'b0, 1'b0);
    fetch(32'h300, 1'b1, 1'b0, 1'b1);

    // misaligned target halts until reset
    redir(JMP, 32'h100, 32'h2, 32'h0);
    fetch(32'h304, 1'b0, 1'b0, 1'b0);
    chk("mis_err", 32'(misalign_err), 32'd1);
    for (int i = 0; i < 3; i++) begin
      if (i == 2) redir(JMP, 32'h400, 32'h0, 32'h0);
      idle(1'b0, 1'b0);
      chk("halt_err", 32'(misalign_err), 32'd1);
    end
    do_reset();
    idle(1'b0, 1'b0);
    fetch(32'h0, 1'b1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  reset, synchronous and active-low.
REQ-004 redir_valid  input  1  redirect request from execute stage, sampled every cycle.
REQ-005 redir_op  input  3  next-PC op: PLUS4 3'b000, BRANCH 3'b001, JUMP 3'b010, JALR 3'b100.
REQ-006 redir_pc  input  32  PC of the redirecting instruction.
REQ-007 redir_imm  input  32  sign-extended immediate.
REQ-008 redir_rs1  input  32  rs1 value, JALR only.
REQ-009 stall  input  1  decode cannot accept an instruction.
REQ-010 imem_req  output  1  instruction memory request.
REQ-011 imem_addr  output  32  fetch address.
REQ-012 imem_ack  input  1  memory accepts the request; imem_rdata is valid in the same cycle.
REQ-013 imem_rdata  input  32  fetched word.
REQ-014 inst_valid  output  1  inst/inst_pc hold a valid instruction.
REQ-015 inst  output  32  fetched instruction, registered.
REQ-016 inst_pc  output  32  address of inst, registered.
REQ-017 misalign_err  output  1  sticky misaligned-target flag.

Function
REQ-018 FSM states: BOOT, REQ, HOLD, HALT; BOOT is entered on reset.
REQ-019 BOOT: imem_req=0; next state REQ; imem_ack is ignored.
REQ-020 REQ: imem_req=1 and imem_addr=pc; imem_addr stays stable until the cycle in which imem_ack=1.
REQ-021 Ack with no redirect and no pending redirect: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1 and pc<=pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0, no error); next state is HOLD if stall=1, else REQ.
REQ-022 REQ cycle with no ack: inst_valid<=0.
REQ-023 HOLD: imem_req=0; inst_valid, inst and inst_pc are held; the block returns to REQ in the first cycle with stall=0, and inst_valid<=0 in that cycle.
REQ-024 Redirect target: BRANCH/JUMP = redir_pc+redir_imm; JALR = (redir_rs1+redir_imm) with bit0 cleared; 32-bit add, carry discarded.
REQ-025 redir_valid with op PLUS4 or an undefined op is ignored.
REQ-026 Redirect in REQ with ack in the same cycle: the fetched word is discarded (inst_valid<=0), pc<=target, and the block stays in REQ.
REQ-027 Redirect in REQ without ack: the target is latched in pend_pc and pend is set; the current request holds its address; on the later ack the data is discarded, pc<=pend_pc, pend<=0.
REQ-028 A further redirect while pend=1 overwrites pend_pc (latest wins); if an ack arrives in the same cycle, the new target is used directly.
REQ-029 Redirect in HOLD: overrides stall; inst_valid<=0, pc<=target, next state REQ.
REQ-030 Redirect in BOOT: pc<=target; the first request uses that target.
REQ-031 Target with [1:0]!=0: misalign_err<=1, next state HALT, pc unchanged.
REQ-032 HALT: imem_req=0, inst_valid=0, misalign_err stays 1; only reset exits.
REQ-033 Latency: inst_valid rises one cycle after the ack cycle; the redirect-to-first-request latency is 1 cycle when no request is outstanding.

Reset
REQ-034 rstn=0 at an edge: state=BOOT, pc=RESET_PC, pend=0, pend_pc=0, imem_req=0, inst_valid=0, inst=0, inst_pc=0, misalign_err=0; any outstanding request is abandoned.
REQ-035 imem_addr shows pc, and therefore equals RESET_PC, while in reset.

Verification
REQ-036 Release reset, ack every cycle, stall=0 -> imem_addr 0,4,8,C on consecutive cycles; inst_valid high from cycle 3 with inst_pc matching.
REQ-037 Ack delayed 3 cycles, BRANCH redirect (redir_pc=0x100, imm=0x20) in cycle 1 of the wait -> imem_addr held; on ack, inst_valid stays 0; next request at 0x120.
REQ-038 JALR with rs1=0x201, imm=0x3 -> next imem_addr=0x204, misalign_err=0.
REQ-039 JUMP with redir_pc=0x100, imm=0x2 -> misalign_err=1, imem_req=0 thereafter until rstn pulse.
REQ-040 stall=1 for 4 cycles after an ack of 0xDEADBEEF at 0x40 -> inst/inst_pc held at 0xDEADBEEF/0x40, no imem_req; a redirect to 0x80 during the stall -> inst_valid=0, request at 0x80.
REQ-041 pc=0xFFFFFFFC with ack -> next imem_addr=0x0; rstn low mid-wait -> imem_req=0 and imem_addr=RESET_PC on the next edge.
